// File: rtl/inpref_row_buffer.sv
// ============================================================================
//  Module   : inpref_row_buffer
//  Brief    : Three-row input prefetch buffer; loads raster pixels per tile
//             mode and streams 3-pixel columns under in_en flow control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inpref_row_buffer #(
  parameter int DW      = 8,
  parameter int ROW_LEN = 8
) (
  input  logic            clk,
  input  logic            fsm_rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            in_en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            out_valid,
  output logic [3*DW-1:0] out_col,
  output logic            out_last,
  output logic            done,
  output logic            busy
);

  localparam int              c_CW       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(ROW_LEN - 1);
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]   r_row [0:2][0:ROW_LEN-1];
  logic [1:0]      r_wr_row;
  logic [c_CW-1:0] r_wr_col;
  logic [c_CW-1:0] r_col_cnt;

  logic w_accept;
  logic w_load_end;
  logic w_emit;
  logic w_emit_last;

  assign wr_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign w_accept    = wr_valid & wr_ready;
  // The load always finishes on the last pixel of row2; the mode only picks the start row.
  assign w_load_end  = w_accept && (r_wr_row == 2'd2) && (r_wr_col == c_LAST_COL);
  assign w_emit      = (r_state == S_STREAM) && in_en;
  assign w_emit_last = w_emit && (r_col_cnt == c_LAST_COL);

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)       w_next = S_LOAD;
      S_LOAD:   if (w_load_end)  w_next = S_STREAM;
      S_STREAM: if (w_emit_last) w_next = S_DONE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < ROW_LEN; c++)
          r_row[r][c] <= '0;
      r_wr_row  <= 2'd0;
      r_wr_col  <= '0;
      r_col_cnt <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr_col <= '0;
            case (mode)
              2'b10: begin
                r_wr_row <= 2'd1;
                for (int c = 0; c < ROW_LEN; c++) r_row[0][c] <= r_row[2][c];
              end
              2'b11: begin
                r_wr_row <= 2'd2;
                for (int c = 0; c < ROW_LEN; c++) begin
                  r_row[0][c] <= r_row[1][c];
                  r_row[1][c] <= r_row[2][c];
                end
              end
              default: r_wr_row <= 2'd0;
            endcase
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_row[r_wr_row][r_wr_col] <= wr_data;
            if (r_wr_col == c_LAST_COL) begin
              r_wr_col <= '0;
              if (r_wr_row != 2'd2) r_wr_row <= r_wr_row + 2'd1;
            end else begin
              r_wr_col <= r_wr_col + c_ONE;
            end
          end
        end
        S_STREAM: begin
          if (in_en) begin
            out_valid <= 1'b1;
            out_col   <= {r_row[2][r_col_cnt], r_row[1][r_col_cnt], r_row[0][r_col_cnt]};
            out_last  <= (r_col_cnt == c_LAST_COL);
            r_col_cnt <= (r_col_cnt == c_LAST_COL) ? '0 : r_col_cnt + c_ONE;
          end
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inpref_row_buffer.sv
// ============================================================================
//  Module   : tb_inpref_row_buffer
//  Brief    : Directed self-checking bench for inpref_row_buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inpref_row_buffer;

  localparam int DW      = 8;
  localparam int ROW_LEN = 8;

  logic            clk = 1'b0;
  logic            fsm_rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            in_en = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [DW-1:0]   wr_data = '0;
  logic            out_valid;
  logic [3*DW-1:0] out_col;
  logic            out_last;
  logic            done;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  inpref_row_buffer #(.DW(DW), .ROW_LEN(ROW_LEN)) dut (
    .clk       (clk),
    .fsm_rst_n (fsm_rst_n),
    .start     (start),
    .mode      (mode),
    .in_en     (in_en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Gaps insert one idle wr_valid cycle before every third pixel.
  task automatic load_pixels(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        @(negedge clk);
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 0) chk("wr_ready_in_load", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = DW'(base + i);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_ready_after_load", 32'(wr_ready), 32'd0);
  endtask

  task automatic stream_tile(input int b2, input int b1, input int b0,
                             input bit stall, input bit pulse_start);
    int         col = 0;
    int         cyc = 0;
    logic       en;
    logic [4:0] pat = 5'b11001;
    logic [7:0] e2, e1, e0;
    while (col < ROW_LEN && cyc < 100) begin
      en    = (stall && cyc < 5) ? pat[cyc] : 1'b1;
      in_en = en;
      start = (pulse_start && cyc == 2);
      @(negedge clk);
      cyc++;
      chk($sformatf("out_valid_cyc%0d", cyc), 32'(out_valid), 32'(en));
      if (en) begin
        e2 = 8'(b2 + col);
        e1 = 8'(b1 + col);
        e0 = 8'(b0 + col);
        chk($sformatf("out_col_c%0d", col), 32'(out_col), 32'({e2, e1, e0}));
        chk($sformatf("out_last_c%0d", col), 32'(out_last), 32'(col == ROW_LEN - 1));
        col++;
      end
    end
    if (col < ROW_LEN) chk("stream_timeout", 32'(col), 32'(ROW_LEN));
    in_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_out_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_wr_ready", 32'(wr_ready), 32'd0);
    chk("still_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    fsm_rst_n = 1'b1;

    // first/stride1 tile
    do_start(2'b01);
    load_pixels(0, 24, 1'b0);
    stream_tile(16, 8, 0, 1'b0, 1'b0);

    // cutting/stride2 with write gaps and an ignored start during streaming
    do_start(2'b10);
    load_pixels(50, 16, 1'b1);
    stream_tile(58, 50, 16, 1'b0, 1'b1);

    // rebuild the first tile, then cutting/stride1 with in_en stalls
    do_start(2'b01);
    load_pixels(0, 24, 1'b0);
    stream_tile(16, 8, 0, 1'b0, 1'b0);
    do_start(2'b11);
    load_pixels(100, 8, 1'b0);
    stream_tile(100, 16, 8, 1'b1, 1'b0);

    // reset in the middle of a load
    do_start(2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'hAA;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #2 fsm_rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("async_rst_out_col", 32'(out_col), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_last", 32'(out_last), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    fsm_rst_n = 1'b1;

    do_start(2'b00);
    load_pixels(200, 24, 1'b0);
    stream_tile(216, 208, 200, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inpref_row_buffer.md
INPREF_ROW_BUFFER -- requirements
Module: inpref_row_buffer

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter ROW_LEN, default 8, meaning pixels per feature-map row (>=2).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port fsm_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin one tile; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 2, prefetch mode latched at start: 00 first/stride2, 01 first/stride1, 10 cutting/stride2, 11 cutting/stride1.
REQ-007 SHALL have port in_en, input, 1, stream enable from the FP/BP controller; low stalls output.
REQ-008 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_data (input, DW), meaning raster-order pixel write handshake.
REQ-009 SHALL have port out_valid, output, 1, meaning out_col holds a valid column this cycle.
REQ-010 SHALL have port out_col, output, 3*DW, meaning {row2[c], row1[c], row0[c]} for column c.
REQ-011 SHALL have ports out_last (output, 1), meaning final column, and done (output, 1), meaning tile complete.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-014 SHALL go IDLE->LOAD on start=1, latching mode; start in any other state SHALL be ignored.
REQ-015 SHALL hold three row registers row0..row2, each ROW_LEN x DW.
REQ-016 On entry to LOAD, first modes (mode[1]=0) SHALL load 3*ROW_LEN pixels into row0, row1, row2 in order.
REQ-017 Cutting stride1 (11) SHALL shift row1->row0, row2->row1 on entry, then load ROW_LEN pixels into row2.
REQ-018 Cutting stride2 (10) SHALL move row2->row0 on entry, then load 2*ROW_LEN pixels into row1, row2.
REQ-019 Cutting mode with no prior tile SHALL use current row contents (zeros after reset), no error.
REQ-020 wr_ready SHALL be 1 only in LOAD; a pixel is accepted on an edge with wr_valid & wr_ready; wr_valid gaps SHALL not advance the load counter.
REQ-021 LOAD SHALL go to STREAM on the edge accepting the final pixel; wr_ready SHALL be 0 the next cycle.
REQ-022 In STREAM, each edge with in_en=1 SHALL register out_valid=1, out_col=column col_cnt, out_last=(col_cnt==ROW_LEN-1), then increment col_cnt.
REQ-023 In STREAM, an edge with in_en=0 SHALL register out_valid=0 and hold col_cnt; no column SHALL be skipped or repeated.
REQ-024 Output latency SHALL be one cycle from in_en sample to out_valid.
REQ-025 On the edge emitting the last column, state SHALL go to DONE; col_cnt SHALL reset to 0.
REQ-026 DONE SHALL last exactly one cycle with done=1, out_valid=0, then return to IDLE.
REQ-027 Horizontal stride SHALL not affect streaming; all ROW_LEN columns emitted in every mode.
REQ-028 Load and column counters SHALL be sized for 3*ROW_LEN and ROW_LEN-1 respectively, no wrap beyond terminal count.

Reset
REQ-029 fsm_rst_n=0 SHALL immediately force IDLE, counters 0, row registers 0, wr_ready=0, out_valid=0, out_col=0, out_last=0, done=0, busy=0.
REQ-030 Reset mid-LOAD or mid-STREAM SHALL discard the tile; next start SHALL behave as after power-on.

Verification
REQ-031 mode=01, write pixels 0..23 -> 8 beats out_col={16+c,8+c,c}, c=0..7, out_last on c=7, done one cycle later.
REQ-032 Then mode=11, write 100..107 -> out_col={100+c,16+c,8+c}.
REQ-033 After REQ-031 tile, mode=10, write 50..65 -> out_col={58+c,50+c,16+c}.
REQ-034 in_en pattern 1,0,0,1,1 in STREAM -> out_valid 1,0,0,1,1 one cycle delayed, columns 0,1,2 consecutive.
REQ-035 wr_valid with gaps, start pulsed during STREAM -> load count exact, start ignored, wr_ready=0 outside LOAD.
REQ-036 fsm_rst_n low after 10 pixels in LOAD -> all outputs 0 asynchronously; fresh mode=00 tile then streams correctly.
